// File: rtl/pcw_line_fetcher_if.sv
// Memory read port between the line fetcher (master) and the SDRAM/BRAM arbiter (slave).
interface pcw_line_fetcher_if #(
  parameter int ADDR_W = 17
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_din;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_din);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_din);
endinterface

// File: rtl/pcw_line_fetcher.sv
// PCW scanline fetcher: roller-RAM lookup, burst fetch into a double-buffered line
// store, and 1/2/4 bpp pixel shift-out of the previously fetched line.
//
// state    | meaning
// IDLE     | nothing to do; waiting for an active-area line_start
// ROLL_LSB | reading low byte of roller entry at R
// ROLL_MSB | reading high byte of roller entry at R+1
// FETCH    | reading pixel byte k at L+8k into the back buffer
// DONE     | line fetched; waiting for next line_start or vblank
module pcw_line_fetcher #(
  parameter int BYTES_PER_LINE = 90,
  parameter int ADDR_W         = 17,
  parameter int BUF_AW         = 7
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce_pix,
  input  logic                line_start,
  input  logic                vblank,
  input  logic                active,
  input  logic [7:0]          fetch_line,
  input  logic [7:0]          roller_ptr,
  input  logic [7:0]          yscroll,
  input  logic [1:0]          mode,
  input  logic                inverse,
  input  logic                disable_vid,
  pcw_line_fetcher_if.master  mem,
  output logic [3:0]          pix_out,
  output logic                fetch_busy,
  output logic                underrun
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ROLL_LSB = 3'd1;
  localparam logic [2:0] S_ROLL_MSB = 3'd2;
  localparam logic [2:0] S_FETCH    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [BUF_AW-1:0] LAST_IDX = BUF_AW'(BYTES_PER_LINE - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] roll_addr;
  logic [ADDR_W-1:0] line_base;
  logic [7:0]        roll_lo;
  logic [BUF_AW-1:0] fetch_idx;
  logic              front_sel;
  logic              vblank_q;

  logic              start;
  logic              busy;
  logic              buf_we;
  logic [7:0]        line_sum;
  logic [16:0]       roll_next;
  logic [16:0]       line_next;

  logic [7:0]        line_buf [0:(2**(BUF_AW+1))-1];

  assign start     = line_start && !vblank;
  assign busy      = (state == S_ROLL_LSB) || (state == S_ROLL_MSB) || (state == S_FETCH);
  assign fetch_busy = busy;
  assign line_sum  = fetch_line + yscroll;
  assign roll_next = {roller_ptr, 9'd0} + {8'd0, line_sum, 1'b0};
  assign line_next = {mem.mem_din, roll_lo[7:3], 1'b0, roll_lo[2:0]};
  // An ack coinciding with line_start is dropped: the new line owns the port.
  assign buf_we    = !reset && !start && (state == S_FETCH) && mem.mem_req && mem.mem_ack;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= S_IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      roll_addr    <= '0;
      line_base    <= '0;
      roll_lo      <= '0;
      fetch_idx    <= '0;
      front_sel    <= 1'b0;
      vblank_q     <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (start) begin
        if (busy) underrun <= 1'b1;
        front_sel   <= ~front_sel;
        roll_addr   <= ADDR_W'(roll_next);
        mem.mem_req <= 1'b0;
        state       <= S_ROLL_LSB;
      end else begin
        case (state)
          S_ROLL_LSB: begin
            if (!mem.mem_req) begin
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= roll_addr;
            end else if (mem.mem_ack) begin
              roll_lo     <= mem.mem_din;
              mem.mem_req <= 1'b0;
              state       <= S_ROLL_MSB;
            end
          end
          S_ROLL_MSB: begin
            if (!mem.mem_req) begin
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= roll_addr + ADDR_W'(1);
            end else if (mem.mem_ack) begin
              line_base   <= ADDR_W'(line_next);
              fetch_idx   <= '0;
              mem.mem_req <= 1'b0;
              state       <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (!mem.mem_req) begin
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= line_base + ADDR_W'({fetch_idx, 3'b000});
            end else if (mem.mem_ack) begin
              mem.mem_req <= 1'b0;
              if (fetch_idx == LAST_IDX) state <= S_DONE;
              else fetch_idx <= fetch_idx + BUF_AW'(1);
            end
          end
          S_DONE: begin
            if (vblank && !vblank_q) state <= S_IDLE;
          end
          S_IDLE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (buf_we) line_buf[{~front_sel, fetch_idx}] <= mem.mem_din;
  end

  logic [2:0]        pix_cnt;
  logic [BUF_AW-1:0] byte_idx;
  logic              past_end;
  logic [7:0]        shreg;
  logic [1:0]        byte_mode;
  logic [7:0]        front_byte;
  logic [7:0]        cur_byte;
  logic [1:0]        cur_mode;
  logic [1:0]        pair;
  logic [3:0]        colour;
  logic [3:0]        pix_next;

  assign front_byte = line_buf[{front_sel, byte_idx}];
  // Pixel 0 of each byte uses the freshly read byte and the live mode.
  assign cur_byte   = (pix_cnt == 3'd0) ? front_byte : shreg;
  assign cur_mode   = (pix_cnt == 3'd0) ? mode : byte_mode;

  always_comb begin
    pair   = 2'b00;
    colour = 4'h0;
    case (pix_cnt[2:1])
      2'd0: pair = cur_byte[7:6];
      2'd1: pair = cur_byte[5:4];
      2'd2: pair = cur_byte[3:2];
      2'd3: pair = cur_byte[1:0];
      default: pair = 2'b00;
    endcase
    if (!past_end) begin
      case (cur_mode)
        2'd1:    colour = {pair, pair};
        2'd2:    colour = pix_cnt[2] ? cur_byte[3:0] : cur_byte[7:4];
        default: colour = {4{cur_byte[3'd7 - pix_cnt]}};
      endcase
    end
  end

  assign pix_next = (disable_vid || !active) ? {4{inverse}}
                                             : (inverse ? ~colour : colour);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pix_cnt   <= '0;
      byte_idx  <= '0;
      past_end  <= 1'b0;
      shreg     <= '0;
      byte_mode <= '0;
      pix_out   <= '0;
    end else if (start) begin
      pix_cnt  <= '0;
      byte_idx <= '0;
      past_end <= 1'b0;
      pix_out  <= {4{inverse}};
    end else if (ce_pix) begin
      pix_out <= pix_next;
      if (active) begin
        if (pix_cnt == 3'd0) begin
          shreg     <= front_byte;
          byte_mode <= mode;
        end
        pix_cnt <= pix_cnt + 3'd1;
        if (pix_cnt == 3'd7) begin
          if (byte_idx == LAST_IDX) past_end <= 1'b1;
          else byte_idx <= byte_idx + BUF_AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pcw_line_fetcher.sv
// Directed bench for pcw_line_fetcher: fetch addressing, pixel modes, underrun, reset and vblank.
module tb_pcw_line_fetcher;
  logic clk_sys = 1'b0;
  logic reset, ce_pix, line_start, vblank, active, inverse, disable_vid;
  logic [7:0] fetch_line, roller_ptr, yscroll;
  logic [1:0] mode;
  logic [3:0] pix_out;
  logic fetch_busy, underrun;

  pcw_line_fetcher_if #(.ADDR_W(17)) bus ();

  pcw_line_fetcher #(.BYTES_PER_LINE(90), .ADDR_W(17), .BUF_AW(7)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .line_start(line_start),
    .vblank(vblank), .active(active), .fetch_line(fetch_line), .roller_ptr(roller_ptr),
    .yscroll(yscroll), .mode(mode), .inverse(inverse), .disable_vid(disable_vid),
    .mem(bus), .pix_out(pix_out), .fetch_busy(fetch_busy), .underrun(underrun)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0]  tmem [0:131071];
  int          lat = 2;
  logic        force_ack = 1'b0;
  logic [16:0] acked [$];
  int          proto_err = 0;
  int          passed = 0;
  int          total = 0;

  // Memory responder: acks after `lat` cycles of a held request; also polices the handshake.
  initial begin
    int cnt;
    logic p_req, p_ack;
    logic [16:0] p_addr;
    cnt = 0; p_req = 1'b0; p_ack = 1'b0; p_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_din = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        if (p_req && p_ack && bus.mem_req) proto_err++;
        if (p_req && !p_ack && bus.mem_req && bus.mem_addr != p_addr) proto_err++;
      end
      p_req  = bus.mem_req;
      p_addr = bus.mem_addr;
      if (force_ack) begin
        bus.mem_ack = 1'b1;
        bus.mem_din = 8'hEE;
      end else if (bus.mem_req && !bus.mem_ack) begin
        cnt++;
        if (cnt >= lat) begin
          bus.mem_ack = 1'b1;
          bus.mem_din = tmem[bus.mem_addr];
          acked.push_back(bus.mem_addr);
          cnt = 0;
        end
      end else begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end
      p_ack = bus.mem_ack;
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic        inv;
    logic        dis;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs [9];

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic do_line();
    line_start = 1'b1; ce_pix = 1'b1;
    step();
    line_start = 1'b0; ce_pix = 1'b0;
    step();
  endtask

  task automatic pixel(input logic [3:0] exp, input string nm);
    ce_pix = 1'b1; active = 1'b1;
    step();
    chk(nm, {28'd0, pix_out}, {28'd0, exp});
    ce_pix = 1'b0; active = 1'b0;
    step();
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (fetch_busy && n < 4000) begin
      step();
      n++;
    end
    chk(nm, {31'd0, fetch_busy}, 32'd0);
  endtask

  initial begin
    int errs, base, reqs;
    logic [31:0] e;
    logic [7:0] b;

    vecs[0] = '{2'd0, 1'b0, 1'b0, 32'hF0FF_0F00, "m0"};
    vecs[1] = '{2'd0, 1'b1, 1'b0, 32'h0F00_F0FF, "m0_inv"};
    vecs[2] = '{2'd1, 1'b0, 1'b0, 32'hAAFF_5500, "m1"};
    vecs[3] = '{2'd1, 1'b1, 1'b0, 32'h5500_AAFF, "m1_inv"};
    vecs[4] = '{2'd2, 1'b0, 1'b0, 32'hBBBB_4444, "m2"};
    vecs[5] = '{2'd2, 1'b1, 1'b0, 32'h4444_BBBB, "m2_inv"};
    vecs[6] = '{2'd3, 1'b0, 1'b0, 32'hF0FF_0F00, "m3"};
    vecs[7] = '{2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, "dis_inv"};
    vecs[8] = '{2'd2, 1'b0, 1'b1, 32'h0000_0000, "dis"};

    for (int i = 0; i < 131072; i++) tmem[i] = 8'(i) ^ 8'h3C;
    tmem[17'h02410] = 8'h2D;
    tmem[17'h02411] = 8'h40;
    tmem[17'h08055] = 8'hB4;

    reset = 1'b1; ce_pix = 1'b0; line_start = 1'b0; vblank = 1'b0; active = 1'b0;
    inverse = 1'b0; disable_vid = 1'b0; mode = 2'd0;
    fetch_line = 8'h03; roller_ptr = 8'h12; yscroll = 8'h05;
    repeat (3) step();
    chk("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", {15'd0, bus.mem_addr}, 32'd0);
    chk("rst_pix_out",  {28'd0, pix_out}, 32'd0);
    chk("rst_busy",     {31'd0, fetch_busy}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    step();
    acked.delete();

    // First fetch: roller lookup then 90 strided byte reads.
    do_line();
    chk("busy_after_ls", {31'd0, fetch_busy}, 32'd1);
    wait_done("fetch1_done");
    chk("ack_count", acked.size(), 32'd92);
    if (acked.size() >= 5) begin
      chk("roll_lsb_addr", {15'd0, acked[0]}, 32'h02410);
      chk("roll_msb_addr", {15'd0, acked[1]}, 32'h02411);
      chk("fetch_addr0",   {15'd0, acked[2]}, 32'h08055);
      chk("fetch_addr1",   {15'd0, acked[3]}, 32'h0805D);
      chk("fetch_addr2",   {15'd0, acked[4]}, 32'h08065);
    end
    errs = 0;
    for (int k = 0; k < 90; k++)
      if (2 + k < acked.size() && acked[2 + k] != 17'(32'h08055 + 8 * k)) errs++;
    chk("fetch_addr_all", errs, 32'd0);

    // Table-driven pixel modes on byte 0 = 0xB4.
    for (int i = 0; i < 9; i++) begin
      mode = vecs[i].mode; inverse = vecs[i].inv; disable_vid = vecs[i].dis;
      e = vecs[i].exp;
      do_line();
      for (int p = 0; p < 8; p++) pixel(e[31 - 4 * p -: 4], vecs[i].name);
      wait_done("vec_fetch_done");
    end
    mode = 2'd0; inverse = 1'b0; disable_vid = 1'b0;

    // Mode change mid-byte takes effect on the next byte (byte1 = 0x61).
    do_line();
    pixel(4'hF, "mc_p0"); pixel(4'h0, "mc_p1"); pixel(4'hF, "mc_p2");
    mode = 2'd2;
    pixel(4'hF, "mc_p3"); pixel(4'h0, "mc_p4"); pixel(4'hF, "mc_p5");
    pixel(4'h0, "mc_p6"); pixel(4'h0, "mc_p7");
    for (int p = 0; p < 4; p++) pixel(4'h6, "mc_b1_hi");
    for (int p = 0; p < 4; p++) pixel(4'h1, "mc_b1_lo");
    wait_done("mc_fetch_done");
    mode = 2'd0;

    // Whole line in mode0, then pixels past the last byte show colour 0.
    do_line();
    for (int k = 0; k < 90; k++) begin
      b = tmem[32'h08055 + 8 * k];
      for (int p = 0; p < 8; p++) pixel(b[7 - p] ? 4'hF : 4'h0, "line_px");
    end
    for (int p = 0; p < 8; p++) pixel(4'h0, "past_end");
    wait_done("line_fetch_done");
    chk("no_underrun", {31'd0, underrun}, 32'd0);

    // Underrun: slow memory, next line_start arrives mid-fetch with a new R.
    lat = 20;
    do_line();
    repeat (150) step();
    fetch_line = 8'h04;
    do_line();
    chk("underrun_set", {31'd0, underrun}, 32'd1);
    chk("restart_req",  {31'd0, bus.mem_req}, 32'd1);
    chk("restart_addr", {15'd0, bus.mem_addr}, 32'h02412);
    lat = 2;
    wait_done("after_underrun_done");
    chk("underrun_sticky", {31'd0, underrun}, 32'd1);

    // Reset mid-FETCH with an ack pending, then a stray ack after reset.
    fetch_line = 8'h03; lat = 20;
    base = acked.size();
    do_line();
    for (int n = 0; n < 500 && acked.size() < base + 3; n++) step();
    chk("reached_fetch", acked.size() >= base + 3, 32'd1);
    repeat (10) step();
    inverse = 1'b1; ce_pix = 1'b1;
    step();
    ce_pix = 1'b0;
    chk("pre_rst_pix", {28'd0, pix_out}, 32'hF);
    reset = 1'b1;
    step();
    chk("mid_rst_req",      {31'd0, bus.mem_req}, 32'd0);
    chk("mid_rst_pix",      {28'd0, pix_out}, 32'd0);
    chk("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    chk("mid_rst_busy",     {31'd0, fetch_busy}, 32'd0);
    reset = 1'b0; inverse = 1'b0; lat = 2;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    reqs = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.mem_req || fetch_busy) reqs++;
    end
    chk("late_ack_ignored", reqs, 32'd0);

    // line_start during vblank is ignored; first one after vblank falls fetches.
    vblank = 1'b1;
    step();
    do_line();
    reqs = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (bus.mem_req || fetch_busy) reqs++;
    end
    chk("vblank_no_fetch", reqs, 32'd0);
    vblank = 1'b0;
    step();
    do_line();
    chk("post_vb_req",  {31'd0, bus.mem_req}, 32'd1);
    chk("post_vb_addr", {15'd0, bus.mem_addr}, 32'h02410);
    wait_done("post_vb_done");

    chk("handshake_protocol", proto_err, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end
endmodule
